// File: rtl/traffic_phase_ctrl_pkg.sv
// Shared state codes, LED bit layout and LED decode for the phase controller.
// Latency: none (constants and a pure combinational function).
// Backpressure: not applicable.
package traffic_pkg;

  // FSM state codes, kept as plain constants so older wrappers can decode State.
  localparam logic [2:0] ST_MAIN_G = 3'd0;
  localparam logic [2:0] ST_MAIN_Y = 3'd1;
  localparam logic [2:0] ST_WALK   = 3'd2;
  localparam logic [2:0] ST_SIDE_G = 3'd3;
  localparam logic [2:0] ST_SIDE_Y = 3'd4;

  // Bit offsets of the three lamps inside each approach's 3-bit LED group.
  localparam int LED_G = 0;
  localparam int LED_Y = 1;
  localparam int LED_R = 2;

  // The decode works on a fixed maximum width; callers truncate to their size.
  localparam int MAX_APPR  = 16;
  localparam int LED_MAX_W = 3*MAX_APPR + 3;

  typedef logic [LED_MAX_W-1:0] led_vec_t;

  // Lamp pattern for a state: approach idx is green or yellow, every other
  // approach red; in WALK all approaches are red and the walk bit (just above
  // the last approach group) is lit.
  function automatic led_vec_t led_vec(input logic [2:0] st, input int idx, input int n_appr);
    led_vec_t v;
    logic     is_grn;
    logic     is_yel;
    v      = '0;
    is_grn = (st == ST_MAIN_G) || (st == ST_SIDE_G);
    is_yel = (st == ST_MAIN_Y) || (st == ST_SIDE_Y);
    for (int i = 0; i < MAX_APPR; i++) begin
      if (i < n_appr) begin
        if (i == idx && is_grn) begin
          v[3*i+LED_G] = 1'b1;
        end else if (i == idx && is_yel) begin
          v[3*i+LED_Y] = 1'b1;
        end else begin
          v[3*i+LED_R] = 1'b1;
        end
      end
    end
    for (int i = 0; i <= MAX_APPR; i++) begin
      if (i == n_appr && st == ST_WALK) begin
        v[3*i] = 1'b1;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_phase_timer.sv
// Phase down-counter: load value on load, otherwise count down to zero and hold.
// Latency: expired is a registered-count compare, valid in the cycle count reaches 0.
// Backpressure: none; load always wins over counting.
module phase_timer #(
  parameter int               CNT_W   = 16,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reload has priority, then decrement until zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register; reset value lets the first phase run without an explicit load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-approach traffic-light sequencer with latched demand, round-robin side service and walk phase.
// Latency: LEDs/Phase_Idx/State/WR_Reset change in the cycle after the phase-expiry cycle.
// Backpressure: none; sensors and WR are sampled every cycle and latched until served.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int N_APPR = 4,
  parameter int CNT_W  = 16,
  parameter int T_BASE = 6,
  parameter int T_EXT  = 3,
  parameter int T_YEL  = 2,
  parameter int T_WALK = 4
) (
  input  logic                      clk,
  input  logic                      Reset_n,
  input  logic                      Prog_Sync,
  input  logic [N_APPR-1:0]         Sensor_Sync,
  input  logic                      WR,
  output logic                      WR_Reset,
  output logic [3*N_APPR:0]         LEDs,
  output logic [$clog2(N_APPR)-1:0] Phase_Idx,
  output logic [2:0]                State
);

  localparam int IDX_W = $clog2(N_APPR);
  localparam int LED_W = 3*N_APPR + 1;

  // Timer reload values: a phase of length T is loaded with T-1.
  localparam logic [CNT_W-1:0] LD_RST  = CNT_W'(2*T_BASE - 1);
  localparam logic [CNT_W-1:0] LD_BASE = CNT_W'(T_BASE - 1);
  localparam logic [CNT_W-1:0] LD_EXT  = CNT_W'(T_EXT - 1);
  localparam logic [CNT_W-1:0] LD_YEL  = CNT_W'(T_YEL - 1);
  localparam logic [CNT_W-1:0] LD_WALK = CNT_W'(T_WALK - 1);

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [N_APPR-1:1] req_q, req_d;
  logic              walk_q, walk_d;
  logic              ext_q, ext_d;
  logic              wr_reset_q, wr_reset_d;
  logic [LED_W-1:0]  leds_q, leds_d;

  logic [N_APPR-1:1] green_mask;
  logic [N_APPR-1:1] req_eff;
  logic              walk_eff;
  logic              any_req;
  logic              sel_vld;
  logic [IDX_W-1:0]  sel_idx;
  logic              go_main;
  logic              go_side;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_expired;

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (LD_RST)
  ) u_timer (
    .clk      (clk),
    .rst_n    (Reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  // Demand as seen by this cycle's decision: latched requests plus any new
  // sensor/WR hit, so a same-cycle arrival is never lost at a phase boundary.
  always_comb begin
    for (int i = 1; i < N_APPR; i++) begin
      green_mask[i] = (state_q == ST_SIDE_G) && (idx_q == IDX_W'(i));
    end
    req_eff  = req_q | (Sensor_Sync[N_APPR-1:1] & ~green_mask);
    walk_eff = walk_q | (WR && (state_q != ST_WALK));
    any_req  = |req_eff;
  end

  // Round-robin pick: first pending side approach after rr_q, wrapping over 1..N_APPR-1.
  // Scanning from the far end means the nearest candidate is written last and wins.
  always_comb begin
    int cand;
    cand    = 0;
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int k = N_APPR-1; k >= 1; k--) begin
      cand = int'(rr_q) + k;
      if (cand > N_APPR-1) begin
        cand = cand - (N_APPR-1);
      end
      if (req_eff[cand]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(cand);
      end
    end
  end

  // Phase sequencing: decisions happen only on timer expiry; Prog_Sync overrides everything.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rr_d       = rr_q;
    req_d      = req_eff;
    walk_d     = walk_eff;
    ext_d      = ext_q;
    wr_reset_d = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    go_main    = 1'b0;
    go_side    = 1'b0;

    if (tmr_expired) begin
      case (state_q)
        ST_MAIN_G: begin
          if (Sensor_Sync[0] && !ext_q) begin
            tmr_load = 1'b1;
            tmr_val  = LD_EXT;
            ext_d    = 1'b1;
          end else if (any_req || walk_eff) begin
            state_d  = ST_MAIN_Y;
            tmr_load = 1'b1;
            tmr_val  = LD_YEL;
          end else begin
            // Nothing waiting: re-arm main green, lamps unchanged.
            go_main = 1'b1;
          end
        end
        ST_MAIN_Y: begin
          if (walk_eff) begin
            state_d    = ST_WALK;
            idx_d      = '0;
            walk_d     = 1'b0;
            wr_reset_d = 1'b1;
            tmr_load   = 1'b1;
            tmr_val    = LD_WALK;
          end else if (sel_vld) begin
            go_side = 1'b1;
          end else begin
            go_main = 1'b1;
          end
        end
        ST_WALK: begin
          if (sel_vld) begin
            go_side = 1'b1;
          end else begin
            go_main = 1'b1;
          end
        end
        ST_SIDE_G: begin
          if (Sensor_Sync[idx_q] && !ext_q) begin
            tmr_load = 1'b1;
            tmr_val  = LD_EXT;
            ext_d    = 1'b1;
          end else begin
            state_d  = ST_SIDE_Y;
            tmr_load = 1'b1;
            tmr_val  = LD_YEL;
          end
        end
        ST_SIDE_Y: go_main = 1'b1;
        default:   go_main = 1'b1;
      endcase
    end

    if (go_main) begin
      state_d  = ST_MAIN_G;
      idx_d    = '0;
      ext_d    = 1'b0;
      tmr_load = 1'b1;
      tmr_val  = LD_BASE;
    end

    if (go_side) begin
      state_d  = ST_SIDE_G;
      idx_d    = sel_idx;
      rr_d     = sel_idx;
      ext_d    = 1'b0;
      tmr_load = 1'b1;
      tmr_val  = LD_BASE;
      for (int i = 1; i < N_APPR; i++) begin
        if (sel_idx == IDX_W'(i)) begin
          req_d[i] = 1'b0;
        end
      end
    end

    if (Prog_Sync) begin
      state_d    = ST_MAIN_G;
      idx_d      = '0;
      rr_d       = '0;
      req_d      = '0;
      walk_d     = 1'b0;
      ext_d      = 1'b0;
      wr_reset_d = 1'b0;
      tmr_load   = 1'b1;
      tmr_val    = LD_RST;
    end
  end

  // Lamp pattern is decoded from the next state so it lines up with State.
  always_comb begin
    leds_d = LED_W'(led_vec(state_d, int'(idx_d), N_APPR));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_MAIN_G;
      idx_q      <= '0;
      rr_q       <= '0;
      req_q      <= '0;
      walk_q     <= 1'b0;
      ext_q      <= 1'b0;
      wr_reset_q <= 1'b0;
      leds_q     <= LED_W'(led_vec(ST_MAIN_G, 0, N_APPR));
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rr_q       <= rr_d;
      req_q      <= req_d;
      walk_q     <= walk_d;
      ext_q      <= ext_d;
      wr_reset_q <= wr_reset_d;
      leds_q     <= leds_d;
    end
  end

  assign WR_Reset  = wr_reset_q;
  assign LEDs      = leds_q;
  assign Phase_Idx = idx_q;
  assign State     = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomised bench for traffic_phase_ctrl against a phase-level reference model.
// Latency: outputs compared 1 time unit after every rising clock edge.
// Backpressure: not applicable; stimulus is free-running.
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;

  localparam int N      = 4;
  localparam int CNT_W  = 16;
  localparam int T_BASE = 6;
  localparam int T_EXT  = 3;
  localparam int T_YEL  = 2;
  localparam int T_WALK = 4;
  localparam int LW     = 3*N + 1;

  logic          clk = 1'b0;
  logic          Reset_n;
  logic          Prog_Sync;
  logic [N-1:0]  Sensor_Sync;
  logic          WR;
  logic          WR_Reset;
  logic [LW-1:0] LEDs;
  logic [1:0]    Phase_Idx;
  logic [2:0]    State;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .N_APPR (N), .CNT_W (CNT_W), .T_BASE (T_BASE),
    .T_EXT (T_EXT), .T_YEL (T_YEL), .T_WALK (T_WALK)
  ) dut (
    .clk         (clk),
    .Reset_n     (Reset_n),
    .Prog_Sync   (Prog_Sync),
    .Sensor_Sync (Sensor_Sync),
    .WR          (WR),
    .WR_Reset    (WR_Reset),
    .LEDs        (LEDs),
    .Phase_Idx   (Phase_Idx),
    .State       (State)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which phase we are in, who owns it, and how many cycles
  // of it remain (counting the current one).
  typedef enum int {P_MG, P_MY, P_WALK, P_SG, P_SY} phase_e;
  phase_e m_ph;
  int     m_idx;
  int     m_left;
  int     m_rr;
  bit     m_ext;
  bit     m_walk;
  bit     m_wrr;
  bit     m_req [N];

  task automatic model_reset();
    m_ph   = P_MG;
    m_idx  = 0;
    m_left = 2*T_BASE;
    m_rr   = 0;
    m_ext  = 1'b0;
    m_walk = 1'b0;
    m_wrr  = 1'b0;
    for (int a = 0; a < N; a++) m_req[a] = 1'b0;
  endtask

  task automatic go_main();
    m_ph   = P_MG;
    m_idx  = 0;
    m_left = T_BASE;
    m_ext  = 1'b0;
  endtask

  task automatic serve_side();
    int c;
    c = m_rr;
    for (int k = 0; k < N-1; k++) begin
      c = c % (N-1) + 1;
      if (m_req[c]) break;
    end
    m_req[c] = 1'b0;
    m_rr     = c;
    m_idx    = c;
    m_ph     = P_SG;
    m_left   = T_BASE;
    m_ext    = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using the inputs present at that edge.
  task automatic model_edge();
    bit any;
    if (Prog_Sync) begin
      model_reset();
      return;
    end
    for (int a = 1; a < N; a++)
      if (Sensor_Sync[a] && !(m_ph == P_SG && m_idx == a)) m_req[a] = 1'b1;
    if (WR && m_ph != P_WALK) m_walk = 1'b1;
    m_wrr = 1'b0;
    if (m_left > 1) begin
      m_left--;
      return;
    end
    any = 1'b0;
    for (int a = 1; a < N; a++) any |= m_req[a];
    case (m_ph)
      P_MG: begin
        if (Sensor_Sync[0] && !m_ext) begin m_left = T_EXT; m_ext = 1'b1; end
        else if (any || m_walk) begin m_ph = P_MY; m_left = T_YEL; end
        else go_main();
      end
      P_MY: begin
        if (m_walk) begin
          m_ph = P_WALK; m_idx = 0; m_left = T_WALK; m_walk = 1'b0; m_wrr = 1'b1;
        end else if (any) serve_side();
        else go_main();
      end
      P_WALK: if (any) serve_side(); else go_main();
      P_SG: begin
        if (Sensor_Sync[m_idx] && !m_ext) begin m_left = T_EXT; m_ext = 1'b1; end
        else begin m_ph = P_SY; m_left = T_YEL; end
      end
      default: go_main();
    endcase
  endtask

  function automatic logic [31:0] exp_leds();
    logic [31:0] v;
    int          lit;
    v = 32'd0;
    if (m_ph == P_WALK)                   lit = -1;
    else if (m_ph == P_MG || m_ph == P_MY) lit = 0;
    else                                  lit = m_idx;
    for (int a = 0; a < N; a++) begin
      if (a != lit)                          v = v | (32'd1 << (3*a + 2));
      else if (m_ph == P_MG || m_ph == P_SG) v = v | (32'd1 << (3*a));
      else                                   v = v | (32'd1 << (3*a + 1));
    end
    if (m_ph == P_WALK) v = v | (32'd1 << (3*N));
    return v;
  endfunction

  function automatic logic [31:0] exp_state();
    case (m_ph)
      P_MG:    return 32'(ST_MAIN_G);
      P_MY:    return 32'(ST_MAIN_Y);
      P_WALK:  return 32'(ST_WALK);
      P_SG:    return 32'(ST_SIDE_G);
      default: return 32'(ST_SIDE_Y);
    endcase
  endfunction

  function automatic logic [31:0] exp_idx();
    return (m_ph == P_SG || m_ph == P_SY) ? 32'(m_idx) : 32'd0;
  endfunction

  task automatic compare_all();
    check("leds",      32'(LEDs),      exp_leds());
    check("state",     32'(State),     exp_state());
    check("phase_idx", 32'(Phase_Idx), exp_idx());
    check("wr_reset",  32'(WR_Reset),  32'(m_wrr));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic do_reset();
    Reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("async_rst_leds", 32'(LEDs), 32'h921);
    #1;
    Reset_n = 1'b1;
  endtask

  int          walks;
  int          budget;
  logic [N-1:0] hold;

  initial begin
    Reset_n     = 1'b0;
    Prog_Sync   = 1'b0;
    Sensor_Sync = '0;
    WR          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_all();
    check("rst_leds", 32'(LEDs), 32'h921);
    Reset_n = 1'b1;

    // Idle: long first main green, then re-armed main greens only.
    repeat (30) step();

    // Single side request during main green.
    do_reset();
    repeat (3) step();
    Sensor_Sync = 4'b0100;
    step();
    Sensor_Sync = '0;
    repeat (30) step();

    // Side 1 held: one extension, then relatched demand after yellow.
    Sensor_Sync = 4'b0010;
    repeat (45) step();
    Sensor_Sync = '0;
    repeat (10) step();

    // Requests on 1 and 3 together (rr pointer left at 1 above).
    Sensor_Sync = 4'b1010;
    step();
    Sensor_Sync = '0;
    repeat (40) step();

    // Walk request with side demand; extra WR pulses during WALK must be ignored.
    walks = 0;
    WR = 1'b1;
    Sensor_Sync = 4'b0100;
    step();
    WR = 1'b0;
    Sensor_Sync = '0;
    for (int c = 0; c < 40; c++) begin
      WR = (m_ph == P_WALK);
      step();
      if (WR_Reset) walks++;
    end
    WR = 1'b0;
    check("walk_count", 32'(walks), 32'd1);
    repeat (20) step();

    // Prog_Sync during side 3 green, with side 3 sensor active.
    Sensor_Sync = 4'b1000;
    step();
    Sensor_Sync = '0;
    budget = 100;
    while (!(m_ph == P_SG && m_idx == 3) && budget > 0) begin
      step();
      budget--;
    end
    check("reach_side3", 32'(budget > 0), 32'd1);
    Prog_Sync   = 1'b1;
    Sensor_Sync = 4'b1000;
    step();
    Prog_Sync   = 1'b0;
    Sensor_Sync = '0;
    check("prog_leds", 32'(LEDs), 32'h921);
    repeat (30) step();

    // Random traffic with occasional held sensors, walk requests and restarts.
    hold = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 60 == 0) hold = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      for (int a = 0; a < N; a++)
        Sensor_Sync[a] = hold[a] | ($urandom_range(0, 9) == 0);
      WR        = ($urandom_range(0, 39) == 0);
      Prog_Sync = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end
    Prog_Sync   = 1'b0;
    Sensor_Sync = '0;
    WR          = 1'b0;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
